// File: rtl/sdio_cdc_pkg.sv
// Shared types and helpers for the SDIO -> AXI toggle-handshake receive side.
package sdio_cdc_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } rx_state_t;

    // Even parity bit: makes the total number of ones (data + bit) even.
    function automatic logic even_par(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sdio_cdc_fifo2.sv
// Two-entry synchronous FIFO; head is the storage word at the read pointer.
// Latency: push visible at head one edge later; pop on empty ignored.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module sdio_cdc_fifo2 #(
    parameter int W = 32
) (
    input  logic         clk_out,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && (cnt != 2'd0);
    assign do_push = push && ((cnt != 2'd2) || do_pop);

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign count = cnt;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/sdio_cdc_req_rx.sv
// Toggle-handshake receiver: captures data_in on a pending request into a 2-entry buffer, returns ack toggle.
// Latency: 1 cycle from synchronized request toggle to m_valid/ack_tgl. Optional SDIO_CDC_RX_PARITY_EN adds parity check + par_err.
// Backpressure: full buffer holds the request in STALL (no ack) until a pop frees a slot.
module sdio_cdc_req_rx
    import sdio_cdc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk_out,
    input  logic              rst_n,
    input  logic              req_tgl_sync,
`ifdef SDIO_CDC_RX_PARITY_EN
    input  logic [DATA_W:0]   data_in,
    output logic              par_err,
`else
    input  logic [DATA_W-1:0] data_in,
`endif
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              ack_tgl,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              stall
);

    rx_state_t         state;
    rx_state_t         state_nxt;
    logic              req_seen;
    logic [1:0]        fifo_cnt;
    logic              pending;
    logic              pop;
    logic              space;
    logic              capture;
    logic              push;
    logic              par_ok;
    logic [DATA_W-1:0] data_word;

`ifdef SDIO_CDC_RX_PARITY_EN
    assign data_word = data_in[DATA_W-1:0];
    assign par_ok    = (data_in[DATA_W] == even_par(64'(data_word)));
`else
    assign data_word = data_in;
    assign par_ok    = 1'b1;
`endif

    assign pending = (req_tgl_sync != req_seen);
    assign m_valid = (fifo_cnt != 2'd0);
    assign pop     = m_valid && m_ready;
    // A full buffer still has room when the head leaves in the same cycle.
    assign space   = (fifo_cnt < 2'd2) || pop;
    assign push    = capture && par_ok;
    assign stall   = (state == STALL);

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    if (space) capture   = 1'b1;
                    else       state_nxt = STALL;
                end
            end
            STALL: begin
                if (!pending) begin
                    state_nxt = IDLE;
                end else if (space) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_seen <= 1'b0;
            ack_tgl  <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                req_seen <= ~req_seen;
                ack_tgl  <= ~ack_tgl;
            end
            if (push) begin
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SDIO_CDC_RX_PARITY_EN
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n)                 par_err <= 1'b0;
        else if (capture && !par_ok) par_err <= 1'b1;
    end
`endif

    sdio_cdc_fifo2 #(
        .W (DATA_W)
    ) u_fifo (
        .clk_out   (clk_out),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (data_word),
        .pop       (pop),
        .count     (fifo_cnt),
        .head      (m_data)
    );

endmodule

// File: tb/tb_sdio_cdc_req_rx.sv
// Directed bench for sdio_cdc_req_rx with a queue-based reference model and per-cycle comparison.
module tb_sdio_cdc_req_rx;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk_out = 1'b0;
    logic          rst_n;
    logic          req_tgl_sync;
`ifdef SDIO_CDC_RX_PARITY_EN
    logic [DW:0]   data_in;
    logic          par_err;
`else
    logic [DW-1:0] data_in;
`endif
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          ack_tgl;
    logic [CW-1:0] xfer_cnt;
    logic          stall;

    int checks   = 0;
    int failures = 0;

    sdio_cdc_req_rx #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk_out      (clk_out),
        .rst_n        (rst_n),
        .req_tgl_sync (req_tgl_sync),
        .data_in      (data_in),
`ifdef SDIO_CDC_RX_PARITY_EN
        .par_err      (par_err),
`endif
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .ack_tgl      (ack_tgl),
        .xfer_cnt     (xfer_cnt),
        .stall        (stall)
    );

    always #5 clk_out = ~clk_out;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: a word queue plus ack/count/stall bookkeeping.
    logic [DW-1:0] q[$];
    logic          md_seen, md_ack, md_stall, md_perr;
    logic [CW-1:0] md_cnt;

    always @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            md_seen  = 1'b0;
            md_ack   = 1'b0;
            md_cnt   = '0;
            md_stall = 1'b0;
            md_perr  = 1'b0;
        end else begin
            logic pend, popv, room, good;
            pend = (req_tgl_sync != md_seen);
            popv = (q.size() > 0) && m_ready;
            room = (q.size() < 2) || popv;
`ifdef SDIO_CDC_RX_PARITY_EN
            good = (data_in[DW] == ^data_in[DW-1:0]);
`else
            good = 1'b1;
`endif
            if (popv) void'(q.pop_front());
            if (pend && room) begin
                md_seen = ~md_seen;
                md_ack  = ~md_ack;
                if (good) begin
                    q.push_back(data_in[DW-1:0]);
                    md_cnt = md_cnt + 16'd1;
                end else begin
                    md_perr = 1'b1;
                end
            end
            md_stall = pend && !room;
        end
    end

    always @(negedge clk_out) begin
        if (rst_n === 1'b1) begin
            chk("m_valid", 64'(m_valid), 64'(q.size() > 0));
            if (q.size() > 0) chk("m_data", 64'(m_data), 64'(q[0]));
            chk("ack_tgl", 64'(ack_tgl), 64'(md_ack));
            chk("xfer_cnt", 64'(xfer_cnt), 64'(md_cnt));
            chk("stall", 64'(stall), 64'(md_stall));
`ifdef SDIO_CDC_RX_PARITY_EN
            chk("par_err", 64'(par_err), 64'(md_perr));
`endif
        end
    end

    task automatic adv(input int n);
        repeat (n) @(negedge clk_out);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] w, input logic bad);
`ifdef SDIO_CDC_RX_PARITY_EN
        data_in = {(^w) ^ bad, w};
`else
        data_in = w;
`endif
        req_tgl_sync = ~req_tgl_sync;
    endtask

    initial begin
        rst_n        = 1'b0;
        req_tgl_sync = 1'b0;
        data_in      = '0;
        m_ready      = 1'b0;
        adv(2);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_ack", 64'(ack_tgl), 64'd0);
        chk("rst_xfer", 64'(xfer_cnt), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        rst_n = 1'b1;
        adv(2);

        // Single transfer, 1-cycle latency.
        m_ready = 1'b1;
        send(32'hDEADBEEF, 1'b0);
        adv(1);
        chk("t1_valid", 64'(m_valid), 64'd1);
        chk("t1_data", 64'(m_data), 64'hDEADBEEF);
        chk("t1_ack", 64'(ack_tgl), 64'd1);
        chk("t1_xfer", 64'(xfer_cnt), 64'd1);
        adv(1);
        m_ready = 1'b0;
        adv(1);

        // Fill buffer, third request stalls.
        send(32'h1, 1'b0); adv(2);
        send(32'h2, 1'b0); adv(2);
        send(32'h3, 1'b0); adv(2);
        chk("st_stall", 64'(stall), 64'd1);
        chk("st_ack", 64'(ack_tgl), 64'd1);
        chk("st_xfer", 64'(xfer_cnt), 64'd3);
        chk("st_head", 64'(m_data), 64'h1);
        m_ready = 1'b1;
        adv(1);
        chk("rel_ack", 64'(ack_tgl), 64'd0);
        chk("rel_stall", 64'(stall), 64'd0);
        chk("rel_head", 64'(m_data), 64'h2);
        adv(1);
        chk("rel_head3", 64'(m_data), 64'h3);
        adv(1);
        chk("rel_empty", 64'(m_valid), 64'd0);

        // Full buffer with pending request and ready: push and pop same edge.
        m_ready = 1'b0;
        send(32'hA, 1'b0); adv(2);
        send(32'hB, 1'b0); adv(2);
        send(32'hC, 1'b0);
        m_ready = 1'b1;
        adv(1);
        chk("pp_ack", 64'(ack_tgl), 64'd1);
        chk("pp_stall", 64'(stall), 64'd0);
        chk("pp_head", 64'(m_data), 64'hB);
        m_ready = 1'b0;
        adv(1);

        // Stall with two words buffered, then async reset between edges.
        send(32'hD, 1'b0);
        adv(2);
        chk("pr_stall", 64'(stall), 64'd1);
        #2;
        rst_n        = 1'b0;
        req_tgl_sync = 1'b0;
        #1;
        chk("ar_valid", 64'(m_valid), 64'd0);
        chk("ar_data", 64'(m_data), 64'd0);
        chk("ar_ack", 64'(ack_tgl), 64'd0);
        chk("ar_xfer", 64'(xfer_cnt), 64'd0);
        chk("ar_stall", 64'(stall), 64'd0);
        adv(2);
        rst_n = 1'b1;
        adv(1);

        // Counter wrap: one transfer per cycle.
        m_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            send(DW'(i), 1'b0);
            adv(1);
        end
        chk("wrap_pre", 64'(xfer_cnt), 64'd65535);
        send(32'h5A5A5A5A, 1'b0);
        adv(1);
        chk("wrap_zero", 64'(xfer_cnt), 64'd0);
        chk("wrap_data", 64'(m_data), 64'h5A5A5A5A);
        adv(2);

`ifdef SDIO_CDC_RX_PARITY_EN
        send(32'h00000007, 1'b1);
        adv(1);
        chk("pe_valid", 64'(m_valid), 64'd0);
        chk("pe_ack", 64'(ack_tgl), 64'(md_ack));
        chk("pe_err", 64'(par_err), 64'd1);
        send(32'h12345678, 1'b0);
        adv(1);
        chk("pg_valid", 64'(m_valid), 64'd1);
        chk("pg_data", 64'(m_data), 64'h12345678);
        chk("pg_err", 64'(par_err), 64'd1);
        adv(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
